mem_ctrl_mp: RTL and testbench
==============================

# mem_ctrl_mp

Multi-port, byte-serial memory controller that succeeds the single-fetch/single-data memory controller. It arbitrates `NUM_PORTS` requesters (instruction fetch, load/store, future cache refill) onto the 8-bit RAM/IO bus using round-robin priority. It supports 1..`DATA_W/8`-byte reads and writes and paces UART writes against `io_buffer_full`. It sits between the pipeline/cache clients and the top-level `mem_*` pins.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of requesters; minimum 1, maximum 8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: request data width; a multiple of 8.
- `IO_GAP`, 1: idle cycles inserted after every IO-space write before the next bus access.

Ports (clock and reset are `clk` and `rst`; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `rdy` in 1: when low, the whole block freezes.
- `req_valid` in NUM_PORTS: request pending, one bit per port.
- `req_we` in NUM_PORTS: 1 = write, 0 = read.
- `req_addr` in NUM_PORTS*ADDR_W: byte address; port p occupies slice [p*ADDR_W +: ADDR_W].
- `req_nbytes` in NUM_PORTS*3: byte count.
- `req_wdata` in NUM_PORTS*DATA_W: write data, little-endian, byte 0 in [7:0].
- `req_done` out NUM_PORTS: one-cycle completion pulse.
- `rdata` out DATA_W: read result, valid while `req_done` is high, zero-extended.
- `busy` out 1: a transaction is in progress.
- `grant_id` out $clog2(NUM_PORTS) (minimum 1 bit): port currently owning the bus.
- `mem_din` in 8: RAM/IO read byte.
- `mem_dout` out 8: write byte.
- `mem_a` out ADDR_W: bus address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART TX buffer full.

## Operation

- States: IDLE, READ, WRITE, IOWAIT, GAP.
- **IDLE:**
  - Round-robin pick among `req_valid` ports, excluding any port whose `req_done` is high this cycle.
  - The priority pointer resets to 0; after granting port g it becomes (g+1) mod NUM_PORTS.
- **Grant latching:** on grant, the block latches addr, nbytes, wdata and we. Later changes on that port's inputs are ignored until done. A `req_valid` drop mid-transaction does not abort.
- **nbytes = 0:** no bus access; `req_done` pulses the cycle after grant with `rdata` = 0.
- **nbytes > DATA_W/8:** clamped to DATA_W/8.
- **IO space** is address[17:16] == 2'b11.
- **Write to IO space while `io_buffer_full` = 1:**
  - Enter IOWAIT and drive `mem_wr` = 0, `mem_a` = 0.
  - Resume the same byte when full = 0.
- **After an IO write completes:** enter GAP for `IO_GAP` cycles with the bus idle, then go to IDLE.
- **READ:**
  - Drive `mem_a` = addr+k for k = 0..n-1 on consecutive cycles.
  - Capture `mem_din` into rdata byte k two edges after address k is launched.
  - Address increments wrap modulo 2^ADDR_W.
- **WRITE:** drive `mem_a` = addr+k, `mem_dout` = byte k, `mem_wr` = 1 for k = 0..n-1.
- **Idle bus:** `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0.
- **`rdy` low:**
  - All state, counters and pointer hold.
  - `mem_wr` is combinationally forced to 0.
  - RAM is gated by the same `rdy`, so read capture timing is preserved across the stall.
- **`rst` asserted mid-transaction:** abort immediately. No `req_done` for the aborted request. All registers return to reset values.

## Timing

- **Reset values:** state IDLE; `req_done` = 0, `rdata` = 0, `busy` = 0, `grant_id` = 0, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0; pointer = 0.
- **Grant at edge E0:** `mem_a` shows the first address after E0; `busy` is 1 from E0.
- **Read of n bytes:**
  - Byte k is captured at edge E(k+2).
  - `req_done` and `rdata` are valid in the cycle after E(n+1).
  - Total latency is n+1 cycles after grant.
- **Write of n bytes:**
  - Byte k is on the bus in the cycle after E(k).
  - `req_done` is high in the cycle after E(n); IOWAIT cycles add one cycle each.
- **`busy`** falls in the `req_done` cycle, unless the block is in GAP.
- **Throughput:** a different port may be granted at the edge ending another port's done cycle, giving zero idle cycles. The same port needs at least one intervening cycle.
- **`req_done`** is exactly one cycle wide per transaction, and only for `grant_id`.

## Structure

- Shared constants in `config.v`: `AddrLen`, IO address tag (2'b11 at bits 17:16), byte-count width, state encodings.
- One natural sub-module: `rr_arbiter`, parametrised by NUM_PORTS. It takes request and mask vectors plus an advance strobe, and returns a one-hot grant, the grant index and a valid flag.

## Test plan

- **Reset:** hold `rst` with random inputs, release -> all outputs 0; `req_valid` = 2'b01, 4-byte read at 0x100 with RAM bytes 11,22,33,44 -> `rdata` = 0x44332211 with done 5 cycles after grant.
- **Round-robin:** both ports request 1-byte reads continuously -> grants alternate 0,1,0,1 with zero idle cycles between done and the next grant.
- **IO pacing:** 1-byte write of 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` stays 0 for 3 cycles, then a single write of 0x41, then `IO_GAP` idle cycles.
- **Stall:** `rdy` low for 2 cycles mid 4-byte write -> no `mem_wr` during the stall, each byte written exactly once, done delayed by 2 cycles.
- **Boundaries:** nbytes = 0 -> done the next cycle with `rdata` = 0; nbytes = 7 -> clamped to 4 bytes; 2-byte write at 0xFFFFFFFF -> second byte written at 0x0.
- **Reset mid-read:** assert `rst` during byte 2 -> immediate idle bus, no `req_done`, pointer back to 0.

Source files
------------

// File: rtl/mem_ctrl_mp_pkg.sv
// mem_ctrl_mp_pkg: shared constants and state encoding for the multi-port memory controller
package mem_ctrl_mp_pkg;
  localparam int ADDR_LEN = 32;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;
  localparam logic [1:0] IO_TAG = 2'b11;
  localparam int BCNT_W = 3;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, READ, WRITE, IOWAIT, GAP} st_e;
endpackage

// File: rtl/mem_ctrl_mp_rr_arbiter.sv
// mem_ctrl_mp_rr_arbiter: round-robin arbiter with a registered priority pointer
module mem_ctrl_mp_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic                 adv,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        idx,
  output logic                 vld
);
  logic [IW-1:0] ptr, p;
  logic [NUM_PORTS-1:0] elig;
  assign elig = req & ~mask;
  // scan from farthest to nearest so the port closest to ptr wins
  always_comb begin
    idx = '0;
    vld = 1'b0;
    p = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      p = IW'((int'(ptr) + i) % NUM_PORTS);
      if (elig[p]) begin
        vld = 1'b1;
        idx = p;
      end
    end
    gnt = vld ? NUM_PORTS'(1) << idx : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (adv && vld) ptr <= idx == IW'(NUM_PORTS - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp: round-robin multi-port byte-serial controller for the 8-bit RAM/IO bus
module mem_ctrl_mp import mem_ctrl_mp_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = ADDR_LEN,
  parameter int DATA_W = 32,
  parameter int IO_GAP = 1,
  localparam int GID_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*3-1:0]      req_nbytes,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [GID_W-1:0]            grant_id,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full
);
  localparam int MAXB = DATA_W / 8;
  localparam int GAP_W = IO_GAP > 1 ? $clog2(IO_GAP) : 1;
  st_e st, st_nx;
  logic [CNT_W-1:0] cnt, n_r, n_sel;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic [NUM_PORTS-1:0] done_r, gnt;
  logic [GID_W-1:0] gid_r, gidx;
  logic [GAP_W-1:0] gap;
  logic [BCNT_W-1:0] nb_sel;
  logic gvld, io, wr_ok, wr_act, rd_act, last_wr;
  mem_ctrl_mp_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .mask(done_r),
    .adv(rdy && st == IDLE),
    .gnt(gnt),
    .idx(gidx),
    .vld(gvld)
  );
  assign nb_sel = req_nbytes[gidx*BCNT_W +: BCNT_W];
  assign n_sel = int'(nb_sel) > MAXB ? CNT_W'(MAXB) : CNT_W'(nb_sel);
  assign io = addr_r[IO_HI:IO_LO] == IO_TAG;
  assign wr_ok = !(io && io_buffer_full);
  assign last_wr = cnt == n_r - 1'b1;
  assign req_done = done_r;
  assign rdata = rdata_r;
  assign grant_id = gid_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else if (rdy) st <= st_nx;
  always_comb begin
    st_nx = st;
    if (st == IDLE) st_nx = !gvld || n_sel == '0 ? IDLE : req_we[gidx] ? WRITE : READ;
    else if (st == READ) st_nx = cnt == n_r ? IDLE : READ;
    else if (st == GAP) st_nx = gap == GAP_W'(IO_GAP - 1) ? IDLE : GAP;
    else st_nx = !wr_ok ? IOWAIT : !last_wr ? WRITE : io && IO_GAP > 0 ? GAP : IDLE;
  end
  // a blocked IO write leaves the bus idle; mem_wr is also gated by rdy
  always_comb begin
    wr_act = (st == WRITE || st == IOWAIT) && wr_ok;
    rd_act = st == READ && cnt < n_r;
    busy = st != IDLE;
    mem_a = wr_act || rd_act ? addr_r + ADDR_W'(cnt) : '0;
    mem_dout = wr_act ? 8'(wdata_r >> (8 * cnt)) : '0;
    mem_wr = wr_act && rdy;
  end
  // read byte k arrives one cycle after its address, so capture lags cnt by one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      n_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      done_r <= '0;
      gid_r <= '0;
      gap <= '0;
    end else if (rdy) begin
      done_r <= '0;
      if (st == IDLE && gvld) begin
        addr_r <= req_addr[gidx*ADDR_W +: ADDR_W];
        wdata_r <= req_wdata[gidx*DATA_W +: DATA_W];
        n_r <= n_sel;
        gid_r <= gidx;
        cnt <= '0;
        gap <= '0;
        rdata_r <= '0;
        done_r <= n_sel == '0 ? gnt : '0;
      end else if (st == READ) begin
        cnt <= cnt + 1'b1;
        if (cnt != '0) rdata_r <= rdata_r | (DATA_W'(mem_din) << (8 * (cnt - 1'b1)));
        if (cnt == n_r) done_r <= NUM_PORTS'(1) << gid_r;
      end else if (wr_act) begin
        cnt <= cnt + 1'b1;
        if (last_wr) done_r <= NUM_PORTS'(1) << gid_r;
      end else if (st == GAP) gap <= gap + 1'b1;
    end
endmodule

// File: tb/tb_mem_ctrl_mp.sv
// tb_mem_ctrl_mp: directed bench for mem_ctrl_mp with a rdy-gated synchronous RAM model
module tb_mem_ctrl_mp;
  logic clk = 0, rst = 1, rdy = 1, io_buffer_full = 0;
  logic [1:0] req_valid = 0, req_we = 0, req_done;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [5:0] req_nbytes = 0;
  logic [31:0] rdata, mem_a;
  logic busy, mem_wr;
  logic [0:0] grant_id;
  logic [7:0] mem_din = 0, mem_dout;
  logic [7:0] ram [1024];
  logic [31:0] wa [$];
  logic [7:0] wd [$];
  int n_cmp = 0, n_bad = 0;

  mem_ctrl_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_nbytes(req_nbytes), .req_wdata(req_wdata),
    .req_done(req_done), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[9:0]];
  always @(posedge clk) if (mem_wr) begin wa.push_back(mem_a); wd.push_back(mem_dout); end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [31:0] a,
                          input logic [2:0] nb, input logic [31:0] d);
    req_valid[p] = v;
    req_we[p] = w;
    req_addr[p*32 +: 32] = a;
    req_nbytes[p*3 +: 3] = nb;
    req_wdata[p*32 +: 32] = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;
    ram[260] = 8'hA5; ram[264] = 8'h5A;
    // reset with random inputs
    rdy = 1'($urandom); req_valid = 2'($urandom); req_we = 2'($urandom);
    req_addr = {$urandom, $urandom}; req_nbytes = 6'($urandom); req_wdata = {$urandom, $urandom};
    io_buffer_full = 1'($urandom);
    repeat (3) tick();
    rst = 0; rdy = 1; req_valid = 0; req_we = 0; req_addr = 0; req_nbytes = 0; req_wdata = 0;
    io_buffer_full = 0;
    #1;
    chk("rst_done", req_done, 0); chk("rst_rdata", rdata, 0); chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0); chk("rst_a", mem_a, 0); chk("rst_dout", mem_dout, 0);
    chk("rst_wr", mem_wr, 0);
    // 4-byte read at 0x100
    set_port(0, 1, 0, 32'h100, 3'd4, 0);
    tick(); req_valid = 0;
    chk("rd4_busy", busy, 1); chk("rd4_gid", grant_id, 0); chk("rd4_a", mem_a, 32'h100);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("rd4_done", req_done, k == 6 ? 2'b01 : 2'b00);
      chk("rd4_a", mem_a, k <= 4 ? 32'h100 + k - 1 : 32'h0);
    end
    chk("rd4_rdata", rdata, 32'h44332211); chk("rd4_busy_done", busy, 0);
    tick();
    chk("rd4_done_clr", req_done, 0);
    // round-robin: pointer sits at port 1 after the previous grant
    set_port(0, 1, 0, 32'h104, 3'd1, 0);
    set_port(1, 1, 0, 32'h108, 3'd1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gid", grant_id, (i % 2 == 0) ? 1 : 0);
      chk("rr_busy", busy, 1);
      chk("rr_a", mem_a, (i % 2 == 0) ? 32'h108 : 32'h104);
      tick(); tick();
      chk("rr_done", req_done, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_rdata", rdata, (i % 2 == 0) ? 32'h5A : 32'hA5);
    end
    req_valid = 0;
    tick();
    // IO write paced by io_buffer_full
    wa.delete(); wd.delete();
    set_port(1, 1, 1, 32'h30000, 3'd1, 32'h41);
    io_buffer_full = 1;
    for (int k = 1; k <= 3; k++) begin
      tick(); req_valid = 0;
      chk("io_wait_wr", mem_wr, 0); chk("io_wait_a", mem_a, 0); chk("io_wait_busy", busy, 1);
    end
    tick(); io_buffer_full = 0; #1;
    chk("io_wr", mem_wr, 1); chk("io_a", mem_a, 32'h30000); chk("io_dout", mem_dout, 8'h41);
    tick();
    chk("io_done", req_done, 2'b10); chk("io_gap_wr", mem_wr, 0); chk("io_gap_busy", busy, 1);
    tick();
    chk("io_idle_busy", busy, 0); chk("io_nwr", wa.size(), 1); chk("io_wd", wd[0], 8'h41);
    // 4-byte write with a 2-cycle rdy stall
    wa.delete(); wd.delete();
    set_port(0, 1, 1, 32'h200, 3'd4, 32'hDDCCBBAA);
    tick(); req_valid = 0;
    chk("st_wr0", mem_wr, 1); chk("st_a0", mem_a, 32'h200); chk("st_d0", mem_dout, 8'hAA);
    tick(); rdy = 0; #1;
    chk("st_stall_wr", mem_wr, 0);
    tick();
    chk("st_stall_wr", mem_wr, 0); chk("st_stall_a", mem_a, 32'h201);
    tick(); rdy = 1; #1;
    chk("st_wr1", mem_wr, 1); chk("st_a1", mem_a, 32'h201); chk("st_d1", mem_dout, 8'hBB);
    for (int k = 5; k <= 7; k++) begin
      tick();
      chk("st_done", req_done, k == 7 ? 2'b01 : 2'b00);
    end
    chk("st_nwr", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("st_log_a", wa[i], 32'h200 + i);
      chk("st_log_d", wd[i], 8'hAA + 8'(i * 8'h11));
    end
    tick();
    // nbytes = 7 clamps to 4 (port 1 has priority now)
    set_port(1, 1, 0, 32'h100, 3'd7, 0);
    tick(); req_valid = 0;
    chk("cl_gid", grant_id, 1);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("cl_done", req_done, k == 6 ? 2'b10 : 2'b00);
      chk("cl_a", mem_a, k <= 4 ? 32'h100 + k - 1 : 32'h0);
    end
    chk("cl_rdata", rdata, 32'h44332211);
    tick();
    // nbytes = 0 completes without a bus access
    set_port(0, 1, 0, 32'h100, 3'd0, 0);
    tick(); req_valid = 0;
    chk("z_done", req_done, 2'b01); chk("z_rdata", rdata, 0);
    chk("z_busy", busy, 0); chk("z_a", mem_a, 0);
    tick();
    chk("z_done_clr", req_done, 0);
    // 2-byte write wrapping past 0xFFFFFFFF
    set_port(1, 1, 1, 32'hFFFFFFFF, 3'd2, 32'hBEEF);
    tick(); req_valid = 0;
    chk("wrap_a0", mem_a, 32'hFFFFFFFF); chk("wrap_d0", mem_dout, 8'hEF); chk("wrap_wr0", mem_wr, 1);
    tick();
    chk("wrap_a1", mem_a, 32'h0); chk("wrap_d1", mem_dout, 8'hBE); chk("wrap_wr1", mem_wr, 1);
    tick();
    chk("wrap_done", req_done, 2'b10);
    tick(); tick();
    // reset during a 4-byte read
    set_port(0, 1, 0, 32'h100, 3'd4, 0);
    tick(); req_valid = 0;
    tick(); tick();
    chk("rr_mid_a", mem_a, 32'h102);
    rst = 1; #1;
    chk("rstm_a", mem_a, 0); chk("rstm_busy", busy, 0); chk("rstm_done", req_done, 0);
    chk("rstm_wr", mem_wr, 0);
    tick();
    chk("rstm_done", req_done, 0);
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rstm_done", req_done, 0);
    end
    set_port(0, 1, 0, 32'h104, 3'd1, 0);
    set_port(1, 1, 0, 32'h108, 3'd1, 0);
    tick(); req_valid = 0;
    chk("rstm_ptr_gid", grant_id, 0); chk("rstm_ptr_a", mem_a, 32'h104);
    tick(); tick();
    chk("rstm_post_done", req_done, 2'b01); chk("rstm_post_rdata", rdata, 32'hA5);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
